// File: rtl/multicycle_control.sv
// Control FSM for the multi-cycle CPU datapath. It walks one instruction
// through 3-5 states starting at FETCH. The outputs are decoded from the
// state register, and op/funct are latched when DECODE is left.
module multicycle_control #(
  parameter bit ILLEGAL_HALT = 1'b0  // 1: an undefined instruction parks in HALT
) (
  input  logic       clk,
  input  logic       reset,          // async, active-low
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_we,
  output logic       ir_we,
  output logic       a_we,
  output logic       b_we,
  output logic       ben,
  output logic       mem_we,
  output logic       reg_we,
  output logic       memin,
  output logic [1:0] regin,
  output logic [1:0] dst,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       bneBEQ,
  output logic [2:0] aluOps,
  output logic       illegal,
  output logic       instr_done,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_I_EXEC    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_JAL       = 4'd12,
    S_JR        = 4'd13,
    S_HALT      = 4'd15
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [5:0] funct_q, funct_d;
  logic       dec_ill;

  // Raw per-state decode. The enables and pulses are gated by reset below.
  logic       pc_we_c, ir_we_c, a_we_c, b_we_c, ben_c, mem_we_c, reg_we_c;
  logic       ill_c, done_c;

  // State and the captured instruction fields
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      funct_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      funct_q <= funct_d;
    end
  end

  // Next state. DECODE branches on the live IR fields and latches them.
  // Later states use only op_q/funct_q.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    funct_d = funct_q;
    dec_ill = 1'b0;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        op_d    = opcode;
        funct_d = funct;
        case (opcode)
          OP_R: begin
            case (funct)
              FN_ADD, FN_SUB, FN_SLT: state_d = S_R_EXEC;
              FN_JR:                  state_d = S_JR;
              default:                dec_ill = 1'b1;
            endcase
          end
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
          OP_ADDI, OP_XORI: state_d = S_I_EXEC;
          OP_BEQ, OP_BNE:   state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
          OP_JAL:           state_d = S_JAL;
          default:          dec_ill = 1'b1;
        endcase
        if (dec_ill) state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
      end
      S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: state_d = S_MEM_WB;
      S_R_EXEC:   state_d = S_R_WB;
      S_I_EXEC:   state_d = S_I_WB;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore output decode. Branch pc_we and the R-type ALU command are the
  // only outputs that look past the state register.
  always_comb begin
    pc_we_c  = 1'b0;
    ir_we_c  = 1'b0;
    a_we_c   = 1'b0;
    b_we_c   = 1'b0;
    ben_c    = 1'b0;
    mem_we_c = 1'b0;
    reg_we_c = 1'b0;
    ill_c    = 1'b0;
    done_c   = 1'b0;
    memin    = 1'b0;
    regin    = 2'd0;
    dst      = 2'd0;
    alusrca  = 2'd0;
    alusrcb  = 2'd0;
    pcsrc    = 2'd0;
    bneBEQ   = 1'b0;
    aluOps   = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        ir_we_c = 1'b1;
        alusrcb = 2'd3;
        pcsrc   = 2'd2;
        pc_we_c = 1'b1;
      end
      S_DECODE: begin
        a_we_c = 1'b1;
        b_we_c = 1'b1;
        ben_c  = 1'b1;
        ill_c  = dec_ill;
      end
      S_MEM_ADDR: begin
        alusrca = 2'd1;
        alusrcb = 2'd1;
      end
      S_MEM_READ: memin = 1'b1;
      S_MEM_WB: begin
        reg_we_c = 1'b1;
        dst      = 2'd1;
        done_c   = 1'b1;
      end
      S_MEM_WRITE: begin
        memin    = 1'b1;
        mem_we_c = 1'b1;
        done_c   = 1'b1;
      end
      S_R_EXEC: begin
        alusrca = 2'd1;
        alusrcb = 2'd2;
        case (funct_q)
          FN_SUB:  aluOps = ALU_SUB;
          FN_SLT:  aluOps = ALU_SLT;
          default: aluOps = ALU_ADD;
        endcase
      end
      S_R_WB: begin
        reg_we_c = 1'b1;
        regin    = 2'd1;
        done_c   = 1'b1;
      end
      S_I_EXEC: begin
        alusrca = 2'd1;
        alusrcb = 2'd1;
        aluOps  = (op_q == OP_XORI) ? ALU_XOR : ALU_ADD;
      end
      S_I_WB: begin
        reg_we_c = 1'b1;
        regin    = 2'd1;
        dst      = 2'd1;
        done_c   = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 2'd1;
        alusrcb = 2'd2;
        aluOps  = ALU_SUB;
        bneBEQ  = (op_q == OP_BNE);
        pc_we_c = ((op_q == OP_BEQ) & zero) | ((op_q == OP_BNE) & ~zero);
        done_c  = 1'b1;
      end
      S_JUMP: begin
        pcsrc   = 2'd1;
        pc_we_c = 1'b1;
        done_c  = 1'b1;
      end
      // r31 takes the current PC, which FETCH already advanced to PC+4
      S_JAL: begin
        pcsrc    = 2'd1;
        pc_we_c  = 1'b1;
        reg_we_c = 1'b1;
        dst      = 2'd2;
        regin    = 2'd2;
        done_c   = 1'b1;
      end
      // JR encodes rt=0, so B is zero and A+B is the target
      S_JR: begin
        alusrca = 2'd1;
        alusrcb = 2'd2;
        pcsrc   = 2'd2;
        pc_we_c = 1'b1;
        done_c  = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset kills every write immediately, even in the middle of a state
  always_comb begin
    pc_we      = pc_we_c  & reset;
    ir_we      = ir_we_c  & reset;
    a_we       = a_we_c   & reset;
    b_we       = b_we_c   & reset;
    ben        = ben_c    & reset;
    mem_we     = mem_we_c & reset;
    reg_we     = reg_we_c & reset;
    illegal    = ill_c    & reset;
    instr_done = done_c   & reset;
    state      = state_q;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Control FSM for the multi-cycle CPU datapath.
- Each cycle it decodes the IR opcode/funct and the ALU zero flag, and drives every register enable, write enable and mux select the datapath consumes.
- One instruction executes as a 3-5 state sequence starting at FETCH.
- Sits beside the datapath top level and is wired one-to-one to its control wires.

Parameters:
- ILLEGAL_HALT, 0, 0: an undefined opcode/funct returns to FETCH. 1: enters HALT until reset.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; low forces state FETCH
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- pc_we, ir_we, a_we, b_we, ben  out  1 each  register enables (PC, IR, A, B, branch-target reg)
- mem_we, reg_we  out  1 each  memory / regfile write enables
- memin  out  1  memory address select: 0=PC, 1=ALU reg
- regin  out  2  regfile data select: 0=MDR, 1=ALU reg, 2=PC
- dst  out  2  write register select: 0=rd, 1=rt, 2=r31
- alusrca  out  2  ALU A select: 0=PC, 1=A reg, 2=branch reg, 3=zero
- alusrcb  out  2  ALU B select: 0=shifted imm, 1=sign-extended imm, 2=B reg, 3=constant 4
- pcsrc  out  2  PC source select: 0=branch path, 1=jump concat, 2=ALU out, 3=ALU reg
- bneBEQ  out  1  0=BEQ, 1=BNE
- aluOps  out  3  ALU command: ADD=000, SUB=001, XOR=010, SLT=011
- illegal  out  1  1-cycle pulse, DECODE saw an undefined instruction
- instr_done  out  1  1-cycle pulse in an instruction's final state
- state  out  4  current state encoding, for debug

Behaviour:
- Moore FSM. Outputs are decoded combinationally from the state register.
- Exceptions to Moore: pc_we in BRANCH, and aluOps in R_EXEC, are functions of the registered op/funct and the zero input.
- Any output not listed for a state is 0.
- While reset is low: state=FETCH, all enables and write enables forced 0, illegal and instr_done forced 0. The first FETCH executes on the first rising edge after release.
- Reset asserted in any state aborts the instruction immediately, with no further writes.
- Encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, I_EXEC=8, I_WB=9, BRANCH=10, JUMP=11, JAL=12, JR=13, HALT=15.
- Instruction set:
  - R-type (opcode 000000) by funct: ADD 100000, SUB 100010, SLT 101010, JR 001000.
  - LW 100011, SW 101011, ADDI 001000, XORI 001110, BEQ 000100, BNE 000101, J 000010, JAL 000011.
- opcode/funct are captured into internal op_q/funct_q on the DECODE-exit edge. Later states use only op_q/funct_q.
- State actions and next state:
  - FETCH: memin=0, ir_we=1, alusrca=0, alusrcb=3, ADD, pcsrc=2, pc_we=1 -> DECODE.
  - DECODE: a_we=1, b_we=1, alusrca=0, alusrcb=0, ADD, ben=1 (latches branch target). Next state:
    - LW/SW -> MEM_ADDR
    - R ALU ops -> R_EXEC
    - ADDI/XORI -> I_EXEC
    - BEQ/BNE -> BRANCH
    - J -> JUMP
    - JAL -> JAL
    - JR -> JR
    - otherwise illegal=1, next FETCH (or HALT if ILLEGAL_HALT=1)
  - MEM_ADDR: alusrca=1, alusrcb=1, ADD -> MEM_READ (LW) or MEM_WRITE (SW).
  - MEM_READ: memin=1 -> MEM_WB.
  - MEM_WB: reg_we=1, regin=0, dst=1, instr_done -> FETCH.
  - MEM_WRITE: memin=1, mem_we=1, instr_done -> FETCH.
  - R_EXEC: alusrca=1, alusrcb=2, aluOps from funct_q -> R_WB.
  - R_WB: reg_we=1, regin=1, dst=0, instr_done -> FETCH.
  - I_EXEC: alusrca=1, alusrcb=1, ADD (ADDI) or XOR (XORI) -> I_WB.
  - I_WB: reg_we=1, regin=1, dst=1, instr_done -> FETCH.
  - BRANCH: alusrca=1, alusrcb=2, SUB, pcsrc=0, bneBEQ=(op_q==BNE), instr_done -> FETCH.
    - pc_we = (BEQ & zero) | (BNE & ~zero).
  - JUMP: pcsrc=1, pc_we=1, instr_done -> FETCH.
  - JAL: pcsrc=1, pc_we=1, reg_we=1, dst=2, regin=2, instr_done -> FETCH.
    - r31 receives the pre-update PC (already PC+4).
  - JR: alusrca=1, alusrcb=2, ADD, pcsrc=2, pc_we=1, instr_done -> FETCH.
    - Relies on rt=0 in the JR encoding, so B=0.
  - HALT: all enables 0, stays in HALT until reset.
- Latency in cycles:
  - LW=5
  - SW, R-type, ADDI, XORI=4
  - BEQ, BNE, J, JAL, JR=3
- At most one of pc_we, reg_we, mem_we plus ir_we fires per state, except JAL, where pc_we and reg_we fire together.

Test Plan:
- Hold reset low for 3 cycles, release -> all enables 0 while low; cycle 1 after release is FETCH with pc_we=1, ir_we=1, alusrcb=3; cycle 2 is DECODE with a_we=1, b_we=1, ben=1.
- Opcode 100011 (LW) -> state sequence 0,1,2,3,4; MEM_WB has reg_we=1, regin=0, dst=1; instr_done high only in cycle 5.
- R-type funct 101010 (SLT) -> R_EXEC aluOps=011; R_WB reg_we=1, dst=0. Then funct 100010 -> aluOps=001.
- BEQ with zero=1 -> BRANCH pc_we=1, pcsrc=0, bneBEQ=0. BNE with zero=1 -> pc_we=0, bneBEQ=1. BNE with zero=0 -> pc_we=1.
- JAL (000011) -> 3 cycles; JAL state has pc_we=1, reg_we=1, dst=2, regin=2, pcsrc=1. JR (funct 001000) -> pcsrc=2, alusrca=1, alusrcb=2.
- Opcode 111111 -> illegal pulse in DECODE, next state FETCH. With ILLEGAL_HALT=1 -> state=15, all enables 0 for 10 cycles. Reset asserted mid-MEM_WRITE -> mem_we drops immediately and state=FETCH.
